// File: rtl/median_moving_average.sv
// Moving average over the last 2^AVG_LOG2 samples from the median filter,
// with a hysteresis level comparator on the averaged output.
module median_moving_average #(
   parameter int DATA_WIDTH = 16,
   parameter int AVG_LOG2   = 3,
   parameter int THR_HI     = 1000,
   parameter int THR_LO     = 800
) (
   input  logic                  ck100m,
   input  logic                  srst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_enable,
   output logic                  filled,
   output logic                  level_hi
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = DATA_WIDTH + AVG_LOG2;
   localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'(N - 1);
   localparam logic [DATA_WIDTH-1:0] HI = DATA_WIDTH'(THR_HI);
   localparam logic [DATA_WIDTH-1:0] LO = DATA_WIDTH'(THR_LO);

   typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [1:0]            rst_sync;
   logic [DATA_WIDTH-1:0] mem [N];
   logic [AVG_LOG2-1:0]   ptr;
   logic [AVG_LOG2:0]     count;
   logic [SW-1:0]         sum;
   logic [SW-1:0]         sum_nxt;
   logic [SW-1:0]         oldest;
   logic [DATA_WIDTH-1:0] avg;
   logic                  accept;
   logic                  emit;

   // Samples are ignored until the released reset has been seen by two flops.
   always_ff @(posedge ck100m or negedge srst_n) begin
      if (!srst_n)
         rst_sync <= '0;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign accept  = enable & ~clear & rst_sync[1];
   assign emit    = (state == RUN) || (count == LAST);
   assign oldest  = (state == RUN) ? SW'(mem[ptr]) : '0;
   assign sum_nxt = sum + SW'(in) - oldest;
   assign avg     = sum_nxt[SW-1:AVG_LOG2];
   assign filled  = (state == RUN);

   always_ff @(posedge ck100m or negedge srst_n) begin
      if (!srst_n)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = EMPTY;
      end else if (accept) begin
         unique case (state)
            EMPTY:   state_nxt = emit ? RUN : FILL;
            FILL:    state_nxt = emit ? RUN : FILL;
            RUN:     state_nxt = RUN;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge ck100m) begin
      if (accept)
         mem[ptr] <= in;
   end

   always_ff @(posedge ck100m or negedge srst_n) begin
      if (!srst_n) begin
         sum        <= '0;
         ptr        <= '0;
         count      <= '0;
         out        <= '0;
         out_enable <= 1'b0;
         level_hi   <= 1'b0;
      end else begin
         out_enable <= 1'b0;
         if (clear) begin
            sum      <= '0;
            ptr      <= '0;
            count    <= '0;
            out      <= '0;
            level_hi <= 1'b0;
         end else if (accept) begin
            sum <= sum_nxt;
            ptr <= ptr + 1'b1;
            if (state != RUN)
               count <= count + 1'b1;
            if (emit) begin
               out        <= avg;
               out_enable <= 1'b1;
               if (avg >= HI)
                  level_hi <= 1'b1;
               else if (avg < LO)
                  level_hi <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_median_moving_average.sv
// Randomized and directed bench for median_moving_average against a
// window-average reference model.
module tb_median_moving_average;

   localparam int N      = 8;
   localparam int THR_HI = 1000;
   localparam int THR_LO = 800;

   logic        clk;
   logic        srst_n;
   logic        enable;
   logic [15:0] din;
   logic        clear;
   logic [15:0] dout;
   logic        out_enable;
   logic        filled;
   logic        level_hi;

   int errors = 0;
   int checks = 0;

   int win[$];
   int m_out;
   bit m_lvl;
   int cap_out[$];
   bit cap_lvl[$];

   logic        obs_oe;
   logic [15:0] obs_out;
   logic        obs_fil;
   logic        obs_lvl;

   median_moving_average #(
      .DATA_WIDTH(16),
      .AVG_LOG2  (3),
      .THR_HI    (THR_HI),
      .THR_LO    (THR_LO)
   ) dut (
      .ck100m    (clk),
      .srst_n    (srst_n),
      .enable    (enable),
      .in        (din),
      .clear     (clear),
      .out       (dout),
      .out_enable(out_enable),
      .filled    (filled),
      .level_hi  (level_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (out_enable) begin
         cap_out.push_back(int'(dout));
         cap_lvl.push_back(level_hi);
      end
   end

   function automatic bit model_push(input int v);
      int s = 0;
      win.push_back(v);
      if (win.size() > N)
         void'(win.pop_front());
      if (win.size() < N)
         return 1'b0;
      foreach (win[i])
         s += win[i];
      m_out = s / N;
      if (m_out >= THR_HI)
         m_lvl = 1'b1;
      else if (m_out < THR_LO)
         m_lvl = 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_clear();
      win.delete();
      m_out = 0;
      m_lvl = 1'b0;
   endfunction

   task automatic do_reset();
      srst_n = 1'b0;
      @(posedge clk);
      #1;
      srst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_clear();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      model_clear();
   endtask

   task automatic drive_sample(input int v, input int gap);
      enable = 1'b1;
      din    = 16'(v);
      @(posedge clk);
      #1;
      enable  = 1'b0;
      obs_oe  = out_enable;
      obs_out = dout;
      obs_fil = filled;
      obs_lvl = level_hi;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      srst_n = 1'b0;
      #2;
      checks++;
      if ({dout, out_enable, filled, level_hi} !== 19'd0) begin
         errors++;
         $display("FAIL reset_during: got %0h expected 0",
                  {dout, out_enable, filled, level_hi});
      end
      do_reset();
      checks++;
      if ({dout, out_enable, filled, level_hi} !== 19'd0) begin
         errors++;
         $display("FAIL reset_after: got %0h expected 0",
                  {dout, out_enable, filled, level_hi});
      end
   endtask

   task automatic test_fill();
      bit e;
      do_reset();
      cap_out.delete();
      for (int i = 0; i < N; i++) begin
         drive_sample(100, 30);
         e = model_push(100);
         checks++;
         if (obs_oe !== e) begin
            errors++;
            $display("FAIL fill_oe[%0d]: got %0d expected %0d", i, obs_oe, e);
         end
         checks++;
         if (obs_fil !== e) begin
            errors++;
            $display("FAIL fill_filled[%0d]: got %0d expected %0d", i, obs_fil, e);
         end
      end
      checks++;
      if (obs_out !== 16'd100) begin
         errors++;
         $display("FAIL fill_out: got %0d expected 100", obs_out);
      end
      checks++;
      if (cap_out.size() != 1) begin
         errors++;
         $display("FAIL fill_strobes: got %0d expected 1", cap_out.size());
      end
   endtask

   task automatic test_step_hyst();
      bit e;
      for (int i = 0; i < 2 * N; i++) begin
         int v = (i < N) ? 1100 : 100;
         drive_sample(v, 5);
         e = model_push(v);
         checks++;
         if (obs_oe !== e || obs_out !== 16'(m_out) || obs_lvl !== m_lvl) begin
            errors++;
            $display("FAIL step[%0d]: got oe=%0d out=%0d lvl=%0d expected oe=%0d out=%0d lvl=%0d",
                     i, obs_oe, obs_out, obs_lvl, e, m_out, m_lvl);
         end
      end
   endtask

   task automatic test_full_scale();
      bit e;
      for (int i = 0; i <= N; i++) begin
         int v = (i < N) ? 65535 : 0;
         drive_sample(v, 3);
         e = model_push(v);
         checks++;
         if (obs_oe !== e || obs_out !== 16'(m_out) || obs_lvl !== m_lvl) begin
            errors++;
            $display("FAIL full[%0d]: got oe=%0d out=%0d lvl=%0d expected oe=%0d out=%0d lvl=%0d",
                     i, obs_oe, obs_out, obs_lvl, e, m_out, m_lvl);
         end
      end
      checks++;
      if (obs_out !== 16'd57343) begin
         errors++;
         $display("FAIL full_after_zero: got %0d expected 57343", obs_out);
      end
   endtask

   task automatic test_clear_collision();
      bit e;
      do_clear();
      checks++;
      if ({dout, filled, level_hi} !== 18'd0) begin
         errors++;
         $display("FAIL clear_zero: got %0h expected 0", {dout, filled, level_hi});
      end
      for (int i = 0; i < 3; i++) begin
         drive_sample(200 + i, 2);
         void'(model_push(200 + i));
      end
      enable = 1'b1;
      clear  = 1'b1;
      din    = 16'd999;
      @(posedge clk);
      #1;
      enable = 1'b0;
      clear  = 1'b0;
      model_clear();
      checks++;
      if ({dout, out_enable, filled} !== 18'd0) begin
         errors++;
         $display("FAIL collide_state: got %0h expected 0",
                  {dout, out_enable, filled});
      end
      cap_out.delete();
      for (int i = 0; i < N; i++) begin
         drive_sample(300 + 10 * i, 2);
         e = model_push(300 + 10 * i);
         checks++;
         if (obs_oe !== e || (e && obs_out !== 16'(m_out))) begin
            errors++;
            $display("FAIL collide_refill[%0d]: got oe=%0d out=%0d expected oe=%0d out=%0d",
                     i, obs_oe, obs_out, e, m_out);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < N; i++)
         drive_sample(500, 2);
      checks++;
      if (obs_out !== 16'd500 || obs_fil !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: got out=%0d filled=%0d expected 500/1",
                  obs_out, obs_fil);
      end
      @(posedge clk);
      #2;
      srst_n = 1'b0;
      #1;
      checks++;
      if ({dout, out_enable, filled, level_hi} !== 19'd0) begin
         errors++;
         $display("FAIL areset_mid: got %0h expected 0",
                  {dout, out_enable, filled, level_hi});
      end
      do_reset();
   endtask

   task automatic test_throughput();
      int vals[20];
      int slow[$];
      int fast[$];
      int exp_q[$];
      foreach (vals[i])
         vals[i] = int'($urandom_range(0, 65535));
      model_clear();
      foreach (vals[i])
         if (model_push(vals[i]))
            exp_q.push_back(m_out);
      do_reset();
      cap_out.delete();
      foreach (vals[i])
         drive_sample(vals[i], 30);
      repeat (3) @(posedge clk);
      #1;
      slow = cap_out;
      do_clear();
      cap_out.delete();
      foreach (vals[i]) begin
         enable = 1'b1;
         din    = 16'(vals[i]);
         @(posedge clk);
         #1;
      end
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      fast = cap_out;
      checks++;
      if (slow.size() != 13 || fast.size() != 13) begin
         errors++;
         $display("FAIL thr_count: got slow=%0d fast=%0d expected 13",
                  slow.size(), fast.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         int s = (i < slow.size()) ? slow[i] : -1;
         int f = (i < fast.size()) ? fast[i] : -1;
         checks++;
         if (s != exp_q[i] || f != exp_q[i]) begin
            errors++;
            $display("FAIL thr_out[%0d]: got slow=%0d fast=%0d expected %0d",
                     i, s, f, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      int exp_o[$];
      bit exp_l[$];
      do_clear();
      cap_out.delete();
      cap_lvl.delete();
      for (int i = 0; i < 60; i++) begin
         int v = (i % 16 < 8) ? int'($urandom_range(0, 1600))
                              : int'($urandom_range(600, 1200));
         drive_sample(v, int'($urandom_range(0, 3)));
         if (model_push(v)) begin
            exp_o.push_back(m_out);
            exp_l.push_back(m_lvl);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cap_out.size() != exp_o.size()) begin
         errors++;
         $display("FAIL rnd_count: got %0d expected %0d",
                  cap_out.size(), exp_o.size());
      end
      for (int i = 0; i < exp_o.size(); i++) begin
         int o = (i < cap_out.size()) ? cap_out[i] : -1;
         bit l = (i < cap_lvl.size()) ? cap_lvl[i] : ~exp_l[i];
         checks++;
         if (o != exp_o[i] || l != exp_l[i]) begin
            errors++;
            $display("FAIL rnd[%0d]: got out=%0d lvl=%0d expected out=%0d lvl=%0d",
                     i, o, l, exp_o[i], exp_l[i]);
         end
      end
   endtask

   initial begin
      srst_n = 1'b0;
      enable = 1'b0;
      clear  = 1'b0;
      din    = '0;
      test_reset();
      test_fill();
      test_step_hyst();
      test_full_scale();
      test_clear_collision();
      test_async_reset();
      test_throughput();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
